// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes,
// ALUOp/PCSource/ALUSrcB selects and the bundle of datapath control strobes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_EXECUTE   = 4'd7,
    ST_R_WB      = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_ADDI_EX   = 4'd11,
    ST_ADDI_WB   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef enum logic [2:0] {
    OPC_RTYPE, OPC_LW, OPC_SW, OPC_BEQ, OPC_BNE, OPC_J, OPC_ADDI, OPC_ILLEGAL
  } op_class_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
  } ctrl_t;

  function automatic op_class_t decode_op(input logic [5:0] op);
    op_class_t cls;
    case (op)
      OP_RTYPE: cls = OPC_RTYPE;
      OP_LW:    cls = OPC_LW;
      OP_SW:    cls = OPC_SW;
      OP_BEQ:   cls = OPC_BEQ;
      OP_BNE:   cls = OPC_BNE;
      OP_J:     cls = OPC_J;
      OP_ADDI:  cls = OPC_ADDI;
      default:  cls = OPC_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/control_out_decode.sv
// Combinational decode of the datapath control strobes from the current state.
// Only the FETCH write strobes and the MEM_WRITE completion flag look at mem_ready.
module control_out_decode
  import mips_ctrl_pkg::*;
(
  input  state_t i_state,
  input  logic   i_bne,
  input  logic   i_mem_ready,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      ST_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_SH2;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEM_ADDR, ST_ADDI_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      ST_MEM_WRITE: begin
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.iord       = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      ST_EXECUTE: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_REG;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        o_ctrl.branch_ne     = i_bne;
        o_ctrl.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCSRC_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
      ST_ADDI_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: state register, next-state logic and the
// opcode-class latch captured in DECODE; outputs come from control_out_decode.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state
);

  state_t    r_state;
  state_t    w_next;
  op_class_t r_op_class;
  op_class_t w_op_class;
  ctrl_t     w_ctrl;
  logic      w_illegal;

  assign w_op_class = decode_op(opcode);
  assign w_illegal  = (r_state == ST_DECODE) && (w_op_class == OPC_ILLEGAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op_class <= OPC_ILLEGAL;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) r_op_class <= w_op_class;
    end
  end

  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_next = ST_FETCH;
      ST_FETCH: w_next = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (w_op_class)
          OPC_LW, OPC_SW:   w_next = ST_MEM_ADDR;
          OPC_RTYPE:        w_next = ST_EXECUTE;
          OPC_BEQ, OPC_BNE: w_next = ST_BRANCH;
          OPC_J:            w_next = ST_JUMP;
          OPC_ADDI:         w_next = ST_ADDI_EX;
          default:          w_next = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR:  w_next = (r_op_class == OPC_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  w_next = mem_ready ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WB:    w_next = ST_FETCH;
      ST_MEM_WRITE: w_next = mem_ready ? ST_FETCH : ST_MEM_WRITE;
      ST_EXECUTE:   w_next = ST_R_WB;
      ST_R_WB:      w_next = ST_FETCH;
      ST_BRANCH:    w_next = ST_FETCH;
      ST_JUMP:      w_next = ST_FETCH;
      ST_ADDI_EX:   w_next = ST_ADDI_WB;
      ST_ADDI_WB:   w_next = ST_FETCH;
      default:      w_next = ST_IDLE;
    endcase
  end

  control_out_decode u_out_decode (
    .i_state     (r_state),
    .i_bne       (r_op_class == OPC_BNE),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // An illegal opcode retires in DECODE, so it also closes the instruction.
  assign illegal_op  = w_illegal;
  assign instr_done  = w_ctrl.instr_done | w_illegal;
  assign PCWrite     = w_ctrl.pc_write;
  assign PCWriteCond = w_ctrl.pc_write_cond;
  assign BranchNe    = w_ctrl.branch_ne;
  assign IorD        = w_ctrl.iord;
  assign MemRead     = w_ctrl.mem_read;
  assign MemWrite    = w_ctrl.mem_write;
  assign IRWrite     = w_ctrl.ir_write;
  assign MemtoReg    = w_ctrl.mem_to_reg;
  assign RegWrite    = w_ctrl.reg_write;
  assign RegDst      = w_ctrl.reg_dst;
  assign ALUSrcA     = w_ctrl.alu_src_a;
  assign PCSource    = w_ctrl.pc_source;
  assign ALUSrcB     = w_ctrl.alu_src_b;
  assign ALUOp       = w_ctrl.alu_op;
  assign state       = r_state;

endmodule
